// File: rtl/enc_pkg.sv
// Shared definitions for the 4-to-2 latching request encoder.
package enc_pkg;

    // Number of active-low request lines handled by the encoder.
    localparam int NLINES = 4;

    // Grant FSM: IDLE waits for an enabled pending request, HOLD presents it.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Fixed-priority pick: index 0 wins over every higher index.
    function automatic logic [1:0] lowest_index(input logic [0:NLINES-1] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NLINES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fall_edge_det.sv
// Registered falling-edge detector for the active-low request lines.
// A line produces an event when its previous sample was high and it is low now.
module fall_edge_det
    import enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:NLINES-1] line_n,
    output logic [0:NLINES-1] fall
);

    logic [0:NLINES-1] prev_n;

    // Previous-sample register; resets high so a line held low through reset
    // release is seen as an event on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_n <= '1;
        end else begin
            prev_n <= line_n;
        end
    end

    // Event is evaluated before the edge and consumed by the parent at that edge.
    always_comb begin
        fall = prev_n & ~line_n;
    end

endmodule

// File: rtl/encoder_4to2_latch.sv
// 4-to-2 priority encoder with latched pending requests and an ack handshake.
// Falling edges on req_n set pend bits; the lowest pending index is granted
// onto {X,Y} while enabled, and held until ack clears it.
module encoder_4to2_latch
    import enc_pkg::*;
#(
    parameter int NLINES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:NLINES-1] req_n,
    input  logic              en_n,
    input  logic              ack,
    output logic              X,
    output logic              Y,
    output logic              valid,
    output logic [0:NLINES-1] pend,
    output logic              overrun
);

    state_e            state;
    state_e            state_next;
    logic [1:0]        code;
    logic [1:0]        code_next;
    logic [0:NLINES-1] pend_next;
    logic              overrun_next;
    logic [0:NLINES-1] fall;

    fall_edge_det u_fall_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_n (req_n),
        .fall   (fall)
    );

    // State, code, pending flags and overrun register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            code    <= 2'b00;
            pend    <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            code    <= code_next;
            pend    <= pend_next;
            overrun <= overrun_next;
        end
    end

    // Grant/ack next-state logic; new events are merged after the ack clear so
    // a coincident re-event keeps its pend bit.
    always_comb begin
        state_next = state;
        code_next  = code;
        pend_next  = pend;
        unique case (state)
            IDLE: begin
                // Only flags already registered are eligible, giving one edge of
                // capture before the grant.
                if (!en_n && (|pend)) begin
                    code_next  = lowest_index(pend);
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (ack) begin
                    pend_next[code] = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        pend_next    = pend_next | fall;
        overrun_next = overrun | (|(fall & pend));
    end

    // Outputs come straight from registers so reset clears them immediately.
    always_comb begin
        valid = (state == HOLD);
        X     = code[1];
        Y     = code[0];
    end

endmodule

// File: tb/tb_encoder_4to2_latch.sv
// Directed self-checking bench for encoder_4to2_latch.
module tb_encoder_4to2_latch;

    logic       clk;
    logic       rst_n;
    logic [0:3] req_n;
    logic       en_n;
    logic       ack;
    logic       X;
    logic       Y;
    logic       valid;
    logic [0:3] pend;
    logic       overrun;

    int checks;
    int failures;

    encoder_4to2_latch #(
        .NLINES (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_n   (req_n),
        .en_n    (en_n),
        .ack     (ack),
        .X       (X),
        .Y       (Y),
        .valid   (valid),
        .pend    (pend),
        .overrun (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic v, input logic [1:0] xy,
                               input logic [3:0] p, input logic ov);
        check({tag, ".valid"}, {3'b000, valid}, {3'b000, v});
        check({tag, ".xy"}, {2'b00, X, Y}, {2'b00, xy});
        check({tag, ".pend"}, pend, p);
        check({tag, ".overrun"}, {3'b000, overrun}, {3'b000, ov});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req_n    = 4'b1111;
        en_n     = 1'b1;
        ack      = 1'b0;
        tick();
        tick();
        check_state("reset", 1'b0, 2'b00, 4'b0000, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single request on line 2 -> code 10.
        en_n  = 1'b0;
        req_n = 4'b1101;
        tick();
        check_state("l2_capture", 1'b0, 2'b00, 4'b0010, 1'b0);
        tick();
        check_state("l2_grant", 1'b1, 2'b10, 4'b0010, 1'b0);
        ack = 1'b1;
        tick();
        check_state("l2_ack", 1'b0, 2'b10, 4'b0000, 1'b0);
        ack   = 1'b0;
        req_n = 4'b1111;
        tick();
        check_state("l2_idle", 1'b0, 2'b10, 4'b0000, 1'b0);

        // Simultaneous lines 0 and 3: priority to 0, then 3.
        req_n = 4'b0110;
        tick();
        check_state("l03_capture", 1'b0, 2'b10, 4'b1001, 1'b0);
        tick();
        check_state("l03_grant0", 1'b1, 2'b00, 4'b1001, 1'b0);
        ack = 1'b1;
        tick();
        check_state("l03_ack0", 1'b0, 2'b00, 4'b0001, 1'b0);
        ack = 1'b0;
        tick();
        check_state("l03_grant3", 1'b1, 2'b11, 4'b0001, 1'b0);
        ack = 1'b1;
        tick();
        check_state("l03_ack3", 1'b0, 2'b11, 4'b0000, 1'b0);
        ack   = 1'b0;
        req_n = 4'b1111;
        tick();

        // Disabled: capture continues, no grant; ack in IDLE is ignored.
        en_n  = 1'b1;
        req_n = 4'b1110;
        tick();
        check_state("dis_capture", 1'b0, 2'b11, 4'b0001, 1'b0);
        ack = 1'b1;
        tick();
        check_state("dis_hold_off", 1'b0, 2'b11, 4'b0001, 1'b0);
        ack  = 1'b0;
        en_n = 1'b0;
        tick();
        check_state("dis_enable", 1'b1, 2'b11, 4'b0001, 1'b0);
        ack = 1'b1;
        tick();
        check_state("dis_ack", 1'b0, 2'b11, 4'b0000, 1'b0);
        ack   = 1'b0;
        req_n = 4'b1111;
        tick();

        // Re-event on granted line 2 -> overrun; plain ack then clears pend.
        req_n = 4'b1101;
        tick();
        tick();
        check_state("ov_grant", 1'b1, 2'b10, 4'b0010, 1'b0);
        req_n = 4'b1111;
        tick();
        req_n = 4'b1101;
        tick();
        check_state("ov_set", 1'b1, 2'b10, 4'b0010, 1'b1);
        ack = 1'b1;
        tick();
        check_state("ov_ack", 1'b0, 2'b10, 4'b0000, 1'b1);
        ack   = 1'b0;
        req_n = 4'b1111;
        tick();

        // Re-event coincident with the ack edge keeps pend[2].
        req_n = 4'b1101;
        tick();
        tick();
        check_state("co_grant", 1'b1, 2'b10, 4'b0010, 1'b1);
        req_n = 4'b1111;
        tick();
        req_n = 4'b1101;
        ack   = 1'b1;
        tick();
        check_state("co_ack", 1'b0, 2'b10, 4'b0010, 1'b1);
        ack = 1'b0;
        tick();
        check_state("co_regrant", 1'b1, 2'b10, 4'b0010, 1'b1);

        // Asynchronous reset mid-HOLD, between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 1'b0, 2'b00, 4'b0000, 1'b0);

        // Line 0 held low through reset release.
        req_n = 4'b0111;
        tick();
        check_state("rel_in_reset", 1'b0, 2'b00, 4'b0000, 1'b0);
        rst_n = 1'b1;
        tick();
        check_state("rel_capture", 1'b0, 2'b00, 4'b1000, 1'b0);
        tick();
        check_state("rel_grant", 1'b1, 2'b00, 4'b1000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
